// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    // Target protocol states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WR        = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD        = 4'd7,
        ST_RD_CACK   = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    // Bus condition patterns, formed as {scl high now and last cycle, previous sda, current sda}
    localparam logic [2:0] COND_START = 3'b110;
    localparam logic [2:0] COND_STOP  = 3'b101;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and reports scl edges and START/STOP.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl;
    logic       w_sda;
    logic [2:0] w_cond;

    // Two-stage synchronisers plus one previous-sample flop per line; idle bus reads as 1
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_cond     = {w_scl & r_scl_prev, r_sda_prev, w_sda};
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    assign o_start    = (w_cond == COND_START);
    assign o_stop     = (w_cond == COND_STOP);

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing a small register file through a write strobe and a read address.
// Host interface: wr_en is a single-clk strobe qualifying wr_addr/wr_data (no back-pressure);
// rd_addr always shows the pointer and rd_data must reflect it by the following clk.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS  = 7'h42,
    parameter int         NUM_REGS = 4,
    localparam int        PTR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire              scl,
    inout  wire              sda,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy,
    output logic [3:0]       dbg_state
);

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REGS - 1);
    localparam logic [8:0]       NUM_REGS_9 = 9'(NUM_REGS);

    state_t           r_state,   w_state_nxt;
    logic [2:0]       r_cnt,     w_cnt_nxt;
    logic [7:0]       r_shift,   w_shift_nxt;
    logic [PTR_W-1:0] r_ptr,     w_ptr_nxt;
    logic             r_sda_low, w_sda_low_nxt;
    logic             r_rw,      w_rw_nxt;
    logic             r_busy,    w_busy_nxt;
    logic             r_wr_en,   w_wr_en_nxt;
    logic [PTR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]       r_wr_data, w_wr_data_nxt;

    logic             w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]       w_byte;
    logic [7:0]       w_shl;
    logic [PTR_W-1:0] w_ptr_inc;

    i2c_bus_sync u_sync (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_sda      (w_sda_s),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // scl is never driven; sda is only ever pulled low
    assign scl = 1'bz;
    assign sda = r_sda_low ? 1'b0 : 1'bz;

    assign w_byte    = {r_shift[6:0], w_sda_s};
    assign w_shl     = r_shift << 1;
    assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 3'd0;
            r_shift   <= 8'd0;
            r_ptr     <= '0;
            r_sda_low <= 1'b0;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_rw      <= w_rw_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // Next-state logic: STOP, then START, then scl rise (sample), then scl fall (drive)
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_low_nxt = r_sda_low;
        w_rw_nxt      = r_rw;
        w_busy_nxt    = r_busy;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = 3'd0;
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_cnt_nxt     = 3'd0;
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_scl_rise) begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WR: begin
                    w_shift_nxt = w_byte;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        if (r_state == ST_ADDR) begin
                            if (w_byte[7:1] == ADDRESS) begin
                                w_state_nxt = ST_ADDR_ACK;
                                w_rw_nxt    = w_byte[0];
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = ST_WAIT_STOP;
                            end
                        end else if (r_state == ST_PTR) begin
                            if ({1'b0, w_byte} < NUM_REGS_9) begin
                                w_ptr_nxt   = w_byte[PTR_W-1:0];
                                w_state_nxt = ST_PTR_ACK;
                            end else begin
                                w_state_nxt = ST_WAIT_STOP;
                                w_busy_nxt  = 1'b0;
                            end
                        end else begin
                            w_wr_en_nxt   = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = w_byte;
                            w_state_nxt   = ST_WR_ACK;
                        end
                    end
                end
                ST_RD: w_cnt_nxt = r_cnt + 3'd1;
                ST_RD_CACK: begin
                    w_ptr_nxt = w_ptr_inc;
                    if (w_sda_s) begin
                        w_state_nxt = ST_WAIT_STOP;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = 3'd1;
                    end
                end
                default: ;
            endcase
        end else if (w_scl_fall) begin
            case (r_state)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (!r_sda_low) begin
                        w_sda_low_nxt = 1'b1;
                    end else begin
                        w_sda_low_nxt = 1'b0;
                        w_cnt_nxt     = 3'd0;
                        if (r_state == ST_ADDR_ACK && r_rw) begin
                            w_shift_nxt   = rd_data;
                            w_sda_low_nxt = ~rd_data[7];
                            w_state_nxt   = ST_RD;
                        end else if (r_state == ST_ADDR_ACK) begin
                            w_state_nxt = ST_PTR;
                        end else begin
                            if (r_state == ST_WR_ACK) w_ptr_nxt = w_ptr_inc;
                            w_state_nxt = ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    if (r_cnt == 3'd0) begin
                        w_sda_low_nxt = 1'b0;
                        w_state_nxt   = ST_RD_CACK;
                    end else begin
                        w_shift_nxt   = w_shl;
                        w_sda_low_nxt = ~w_shl[7];
                    end
                end
                ST_RD_CACK: begin
                    if (r_cnt != 3'd0) begin
                        w_shift_nxt   = rd_data;
                        w_sda_low_nxt = ~rd_data[7];
                        w_cnt_nxt     = 3'd0;
                        w_state_nxt   = ST_RD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_addr   = r_ptr;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
